// File: rtl/rgb2hsv_pkg.sv
// Shared constants for the RGB->HSV converter: FSM encodings, sextant codes,
// divider iteration count and the exact divide-by-6 multiplier.
package rgb2hsv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DIVIDE = 3'd2,
        ST_FINAL  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [2:0] SEXT_0 = 3'd0;
    localparam logic [2:0] SEXT_1 = 3'd1;
    localparam logic [2:0] SEXT_2 = 3'd2;
    localparam logic [2:0] SEXT_3 = 3'd3;
    localparam logic [2:0] SEXT_4 = 3'd4;
    localparam logic [2:0] SEXT_5 = 3'd5;

    localparam int DIV_ITER   = 9;
    // (h*683)>>12 equals floor(h/6) for every h in 0..1535
    localparam int DIV6_MUL   = 683;
    localparam int DIV6_SHIFT = 12;

endpackage

// File: rtl/rgb2hsv_if.sv
// Streaming handshake bundle: RGB in with valid/ready, HSV out with valid/ready.
interface rgb2hsv_if;
    logic [23:0] tRGB;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] tHSV;
    logic        out_valid;
    logic        out_ready;

    modport master (output tRGB, in_valid, out_ready,
                    input  in_ready, tHSV, out_valid);
    modport slave  (input  tRGB, in_valid, out_ready,
                    output in_ready, tHSV, out_valid);
endinterface

// File: rtl/rgb2hsv_div.sv
// Serial restoring divider: 16-bit dividend / 8-bit divisor -> 9-bit quotient
// in DIV_ITER cycles. A zero divisor runs the same cycle count but yields 0.
module rgb2hsv_div
    import rgb2hsv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [8:0]  quotient,
    output logic        done
);

    logic [3:0] cnt;
    logic [8:0] rem;
    logic [8:0] dvd_lo;
    logic [7:0] dsr;
    logic       skip;
    logic [8:0] trial;
    logic       fits;

    // Caller guarantees quotient < 512, so dividend[15:9] < divisor and the
    // partial remainder always fits in 8 bits before the shift.
    always_comb begin
        trial = {rem[7:0], dvd_lo[8]};
        fits  = (trial >= {1'b0, dsr});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            rem      <= '0;
            dvd_lo   <= '0;
            dsr      <= '0;
            skip     <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            cnt      <= 4'(DIV_ITER);
            rem      <= {2'b00, dividend[15:9]};
            dvd_lo   <= dividend[8:0];
            dsr      <= divisor;
            skip     <= (divisor == 8'd0);
            quotient <= '0;
        end else if (cnt != 4'd0) begin
            cnt    <= cnt - 4'd1;
            dvd_lo <= {dvd_lo[7:0], 1'b0};
            if (!skip) begin
                rem      <= fits ? (trial - {1'b0, dsr}) : trial;
                quotient <= {quotient[7:0], fits};
            end
        end
    end

    assign done = (cnt == 4'd1);

endmodule

// File: rtl/rgb2hsv.sv
// RGB -> HSV converter on the 256-step-per-sextant hue circle, fixed 11-cycle
// latency from acceptance to out_valid, one conversion in flight at a time.
//
// state  | meaning
// IDLE   | in_ready high, waiting for in_valid
// LOAD   | operands derived from registered RGB, dividers started
// DIVIDE | both serial dividers iterating (9 cycles)
// FINAL  | clamp f, hue = (sext*256+f)/6, register tHSV
// DONE   | out_valid held until out_ready
module rgb2hsv
    import rgb2hsv_pkg::*;
(
    input logic     clk,
    input logic     rst_n,
    rgb2hsv_if.slave bus
);

    state_t      state, state_nxt;
    logic [7:0]  r, g, b;
    logic [7:0]  vmax, vmin, delta, n;
    logic [2:0]  sext;
    logic [15:0] s_dividend, f_dividend;
    logic [8:0]  s_q, f_q;
    logic        s_done, f_done;
    logic        div_start;
    logic [7:0]  f_clamp, s_out, hue;
    logic [10:0] h;
    logic [19:0] h_prod;
    logic        accept;

    assign accept    = (state == ST_IDLE) && bus.in_valid;
    assign div_start = (state == ST_LOAD);

    // Max ties resolve R > G > B.
    always_comb begin
        sext = SEXT_0;
        n    = '0;
        vmax = r;
        vmin = r;
        if (r >= g && r >= b) begin
            vmax = r;
            if (g >= b) begin
                sext = SEXT_0; n = g - b; vmin = b;
            end else begin
                sext = SEXT_5; n = r - b; vmin = g;
            end
        end else if (g >= b) begin
            vmax = g;
            if (r > b) begin
                sext = SEXT_1; n = g - r; vmin = b;
            end else begin
                sext = SEXT_2; n = b - r; vmin = r;
            end
        end else begin
            vmax = b;
            if (r < g) begin
                sext = SEXT_3; n = b - g; vmin = r;
            end else begin
                sext = SEXT_4; n = r - g; vmin = g;
            end
        end
        delta = vmax - vmin;
    end

    assign s_dividend = 16'(delta) * 16'd255;
    assign f_dividend = {n, 8'h00};

    rgb2hsv_div u_div_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (s_dividend),
        .divisor  (vmax),
        .quotient (s_q),
        .done     (s_done)
    );

    rgb2hsv_div u_div_f (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (f_dividend),
        .divisor  (delta),
        .quotient (f_q),
        .done     (f_done)
    );

    always_comb begin
        f_clamp = f_q[8] ? 8'hFF : f_q[7:0];
        s_out   = s_q[8] ? 8'hFF : s_q[7:0];
        h       = {sext, f_clamp};
        h_prod  = 20'(h) * 20'(DIV6_MUL);
        hue     = 8'(h_prod >> DIV6_SHIFT);
        if (delta == 8'd0) begin
            hue   = 8'd0;
            s_out = 8'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.in_valid) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_DIVIDE;
            ST_DIVIDE: if (s_done && f_done) state_nxt = ST_FINAL;
            ST_FINAL:  state_nxt = ST_DONE;
            ST_DONE:   if (bus.out_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            r             <= '0;
            g             <= '0;
            b             <= '0;
            bus.tHSV      <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r <= bus.tRGB[23:16];
                b <= bus.tRGB[15:8];
                g <= bus.tRGB[7:0];
            end
            if (state == ST_FINAL) begin
                bus.tHSV      <= {hue, s_out, vmax};
                bus.out_valid <= 1'b1;
            end else if (state == ST_DONE && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

    // Held low during reset so nothing is offered to a block being cleared.
    assign bus.in_ready = rst_n && (state == ST_IDLE);

endmodule

// File: tb/tb_rgb2hsv.sv
// Directed self-checking bench for rgb2hsv: colour vectors, latency,
// backpressure, mid-conversion reset and back-to-back conversions.
module tb_rgb2hsv;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    rgb2hsv_if bus ();

    rgb2hsv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one input, returns edges from acceptance to out_valid (or 40 on timeout).
    task automatic convert(input logic [23:0] rgb, output logic [23:0] hsv, output int lat);
        @(negedge clk);
        bus.tRGB      = rgb;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        hsv = bus.tHSV;
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.tRGB      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.tHSV !== 24'h000000) begin
            errors++; $display("FAIL reset_tHSV: got %h expected 000000", bus.tHSV);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_colors();
        logic [23:0] vin [7];
        logic [23:0] vexp [7];
        logic [23:0] hsv;
        int          lat;
        vin[0] = 24'hFF0000; vexp[0] = 24'h00FFFF;
        vin[1] = 24'h0000FF; vexp[1] = 24'h55FFFF;
        vin[2] = 24'h00FF00; vexp[2] = 24'hAAFFFF;
        vin[3] = 24'hFF00FF; vexp[3] = 24'h2AFFFF;
        vin[4] = 24'h808080; vexp[4] = 24'h000080;
        vin[5] = 24'h000000; vexp[5] = 24'h000000;
        vin[6] = 24'hC83264; vexp[6] = 24'h0EBFC8;
        for (int i = 0; i < 7; i++) begin
            convert(vin[i], hsv, lat);
            checks++;
            if (hsv !== vexp[i]) begin
                errors++; $display("FAIL color_%0d_tHSV: in %h got %h expected %h", i, vin[i], hsv, vexp[i]);
            end
            checks++;
            if (lat != 11) begin
                errors++; $display("FAIL color_%0d_latency: got %0d expected 11", i, lat);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        bus.tRGB     = 24'hC83264;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.tRGB = 24'hFF0000;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 11) begin
            errors++; $display("FAIL bp_latency: got %0d expected 11", lat);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.tHSV !== 24'h0EBFC8 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got tHSV=%h out_valid=%b in_ready=%b expected 0ebfc8/1/0",
                         i, bus.tHSV, bus.out_valid, bus.in_ready);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        consume();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] hsv;
        int          lat;
        int          bad;
        @(negedge clk);
        bus.tRGB     = 24'hFF0000;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.tHSV !== 24'h0) begin
            errors++; $display("FAIL rstmid_during: got in_ready=%b tHSV=%h expected 0/000000", bus.in_ready, bus.tHSV);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_ready: got %b expected 1", bus.in_ready);
        end
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid !== 1'b0 || bus.tHSV !== 24'h0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rstmid_no_output: got %0d bad cycles expected 0", bad);
        end
        convert(24'h00FF00, hsv, lat);
        checks++;
        if (hsv !== 24'hAAFFFF || lat != 11) begin
            errors++; $display("FAIL rstmid_next: got %h lat %0d expected aaffff lat 11", hsv, lat);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [23:0] hsv;
        int          lat;
        int          busy_ready;
        convert(24'hFF00FF, hsv, lat);
        checks++;
        if (hsv !== 24'h2AFFFF) begin
            errors++; $display("FAIL b2b_first: got %h expected 2affff", hsv);
        end
        consume();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_turnaround: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
        end
        bus.tRGB     = 24'h0000FF;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        busy_ready   = 0;
        lat          = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready !== 1'b0) busy_ready++;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (bus.tHSV !== 24'h55FFFF || lat != 11) begin
            errors++; $display("FAIL b2b_second: got %h lat %0d expected 55ffff lat 11", bus.tHSV, lat);
        end
        checks++;
        if (busy_ready != 0) begin
            errors++; $display("FAIL b2b_busy_ready: got %0d ready cycles while busy expected 0", busy_ready);
        end
        consume();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_colors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb2hsv.md
RGB2HSV -- requirements
Module: rgb2hsv

Interface
REQ-001 Parameter none; all widths fixed at 8 bits per channel.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tRGB  input  24  colour in; packing {R,B,G}: [23:16]=R, [15:8]=B, [7:0]=G.
REQ-005 in_valid  input  1  tRGB valid this cycle.
REQ-006 in_ready  output  1  block idle, will accept tRGB.
REQ-007 tHSV  output  24  result; packing {H,S,V}: [23:16]=H, [15:8]=S, [7:0]=V.
REQ-008 out_valid  output  1  tHSV valid, held until consumed.
REQ-009 out_ready  input  1  downstream accepts tHSV.

Function
REQ-010 The block SHALL accept tRGB on the rising edge where in_valid && in_ready, registering R, G and B; in_ready SHALL be high only in IDLE.
REQ-011 The FSM SHALL use states IDLE -> LOAD (1 cycle) -> DIVIDE (9 cycles) -> FINAL (1 cycle) -> DONE, then return to IDLE on out_valid && out_ready.
REQ-012 out_valid SHALL rise on the 11th rising edge after the accepting edge; latency SHALL be fixed for every input, including gray and black.
REQ-013 In DONE, tHSV and out_valid SHALL hold stable while out_ready is low; in_valid is ignored outside IDLE.
REQ-014 On the handshake edge in DONE, out_valid SHALL drop and in_ready SHALL be high the next cycle; there is no overlap, so throughput is one conversion per 12 or more cycles.
REQ-015 Arithmetic: V=max(R,G,B); delta=max-min; S=floor(255*delta/max); S=0 when max=0.
REQ-016 The sextant and rising numerator n SHALL be selected as follows, with max ties resolved R > G > B:
  - max R, G>=B: sext 0, n=G-B
  - max R, G<B: sext 5, n=R-B
  - max G, R>B: sext 1, n=G-R
  - max G, R<=B: sext 2, n=B-R
  - max B, R<G: sext 3, n=B-G
  - max B, R>=G: sext 4, n=R-G
REQ-017 Hue SHALL be computed as:
  - f = min(floor(256*n/delta), 255)
  - h = sext*256 + f (11 bits, 0..1535)
  - H = floor(h/6), exact for all h
REQ-018 When delta=0, H=0 and S=0 with V=max; the S and f divisions SHALL NOT be performed by zero.
REQ-019 The S and f divisions SHALL run concurrently during DIVIDE, each as a 9-iteration restoring divider. The S quotient never exceeds 255, and the f quotient of 256 SHALL be clamped.
REQ-020 The /6 in REQ-017 SHALL be exact; a constant multiply (h*683)>>12 is permitted.
REQ-021 The block SHALL be the inverse of the team's HSV->RGB converter, using the same 256-step hue circle and the same tRGB/tHSV packings.

Reset
REQ-022 On rst_n low, asynchronously: FSM=IDLE, out_valid=0, tHSV=24'h000000, in_ready=0 while rst_n is low, and divider state cleared.
REQ-023 Reset mid-conversion SHALL abort the conversion with no output; after release, in_ready SHALL be 1 on the first clock.

Structure
REQ-024 A shared package SHALL hold the FSM state encodings, the sextant constants 0..5, the divider iteration count (9) and the /6 constant (683, shift 12).
REQ-025 A sub-module rgb2hsv_div SHALL implement the serial divider: 16-bit dividend, 8-bit divisor, 9-bit quotient, start/done. It SHALL be instantiated twice, once for S and once for f.

Verification
REQ-026 Red: tRGB=24'hFF0000 -> tHSV=24'h00FFFF; out_valid on the 11th edge after acceptance.
REQ-027 Green and blue: 24'h0000FF -> 24'h55FFFF; 24'h00FF00 -> 24'hAAFFFF.
REQ-028 Clamp: yellow 24'hFF00FF -> 24'h2AFFFF (f=256 clamped to 255).
REQ-029 Degenerate and mid-range inputs:
  - gray 24'h808080 -> 24'h000080
  - black 24'h000000 -> 24'h000000
  - R=200,G=100,B=50 (24'hC83264) -> S=191, V=200, H=floor((0*256+floor(256*50/150))/6)=14; tHSV=24'h0EBFC8
REQ-030 Backpressure and reset:
  - out_ready low 5 cycles -> tHSV stable, in_ready low, second in_valid ignored
  - rst_n pulsed at the 5th edge of a conversion -> out_valid stays 0, tHSV=0, next input converts correctly
